// File: rtl/seg_num_disp.sv
// Multi-digit seven-segment decimal driver: serial shift-add-3 binary to BCD, then
// active-low digit latch with sign/overflow. Build macro SEG_LZB_EN enables leading-zero blanking.

module seg_num_disp_digit (
  input  logic [3:0] nib,
  input  logic       ovf_all,
  input  logic       show_dig,
  input  logic       show_minus,
  input  logic       pad_zero,
  output logic [7:0] seg
);
  logic [7:0] pat;

  always_comb begin
    case (nib)
      4'd0:    pat = 8'h03;
      4'd1:    pat = 8'h9F;
      4'd2:    pat = 8'h25;
      4'd3:    pat = 8'h0D;
      4'd4:    pat = 8'h99;
      4'd5:    pat = 8'h49;
      4'd6:    pat = 8'h41;
      4'd7:    pat = 8'h1F;
      4'd8:    pat = 8'h01;
      4'd9:    pat = 8'h09;
      default: pat = 8'hFF;
    endcase
  end

  always_comb begin
    if (ovf_all)         seg = 8'hFD;
    else if (show_dig)   seg = pat;
    else if (show_minus) seg = 8'hFD;
    else if (pad_zero)   seg = 8'h03;
    else                 seg = 8'hFF;
  end
endmodule

module seg_num_disp #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_signed,
  output logic [DIGITS*8-1:0]   seg,
  output logic                  done,
  output logic                  ovf
);
  // Nibble count = decimal digits of 2^WIDTH-1, plus one spare.
  function automatic int calc_nb(input int w);
    longint unsigned v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    for (int i = 0; i < 24; i++)
      if (v != 0) begin
        n++;
        v = v / 10;
      end
    return n + 1;
  endfunction

  localparam int NB = calc_nb(WIDTH);
  localparam int CW = $clog2(WIDTH);
`ifdef SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
  typedef struct packed {
    logic [WIDTH-1:0] mag;
    logic             neg;
  } req_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            cnt;
  logic [WIDTH-1:0]         mag;
  logic                     neg;
  logic [NB-1:0][3:0]       bcd, bcd_adj;
  logic                     accept, cnv_en, load_en;
  req_t                     req;
  int                       n_sig, need, minus_pos;
  logic                     ovf_nxt;
  logic [DIGITS-1:0][3:0]   nib;
  logic [DIGITS-1:0][7:0]   seg_nxt;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nxt = CONV;
      CONV:    if (cnt == CW'(WIDTH-1))  state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // control decode
  always_comb begin
    accept  = 1'b0;
    cnv_en  = 1'b0;
    load_en = 1'b0;
    case (state)
      IDLE:    accept  = in_valid && in_ready;
      CONV:    cnv_en  = 1'b1;
      LOAD:    load_en = 1'b1;
      default: ;
    endcase
  end

  // Negate before storing so -2^(WIDTH-1) still yields its correct unsigned magnitude.
  always_comb begin
    req.neg = in_signed && in_data[WIDTH-1];
    req.mag = req.neg ? (~in_data + 1'b1) : in_data;
  end

  always_comb begin
    for (int k = 0; k < NB; k++)
      bcd_adj[k] = (bcd[k] >= 4'd5) ? bcd[k] + 4'd3 : bcd[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag <= '0;
      neg <= 1'b0;
      bcd <= '0;
      cnt <= '0;
    end else if (accept) begin
      mag <= req.mag;
      neg <= req.neg;
      bcd <= '0;
      cnt <= '0;
    end else if (cnv_en) begin
      {bcd, mag} <= {bcd_adj, mag} << 1;
      cnt        <= cnt + 1'b1;
    end
  end

  always_comb begin
    n_sig = 1;
    for (int k = 0; k < NB; k++)
      if (bcd[k] != 4'd0) n_sig = k + 1;
    need      = n_sig + (neg ? 1 : 0);
    ovf_nxt   = (need > DIGITS);
    minus_pos = LZB ? n_sig : DIGITS - 1;
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    if (i < NB) begin : g_nib
      assign nib[i] = bcd[i];
    end else begin : g_pad
      assign nib[i] = 4'd0;
    end
    seg_num_disp_digit u_dig (
      .nib        (nib[i]),
      .ovf_all    (ovf_nxt),
      .show_dig   (i < n_sig),
      .show_minus (neg && (i == minus_pos)),
      .pad_zero   (!LZB),
      .seg        (seg_nxt[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg      <= '1;
      ovf      <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      done     <= load_en;
      in_ready <= (state_nxt == IDLE);
      if (load_en) begin
        seg <= seg_nxt;
        ovf <= ovf_nxt;
      end
    end
  end
endmodule
